ddr_cmd_sequencer: RTL and testbench

Converts single read/write requests from the controller front end into DDR4 command-pin sequences (PRE, ACT, RD, WR) on the DIMM-side bus. It sits directly upstream of the DIMM model and drives `cs_n`, `act_n`, the multiplexed RAS/CAS/WE/address pins, `bg_addr` and `ba_addr`. It tracks the open row of each of the 16 banks (bg × ba) and enforces tRP, tRCD and tCCD spacing with cycle counters.

---
 rtl/ddr_cmd_sequencer_if.sv | 37 +++
 rtl/ddr_cmd_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ddr_cmd_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_sequencer_if.sv
// Request handshake plus DDR4 command/address pin bundle.
// slave: sequencer side (takes requests, drives pins); master: front end / DIMM side.
interface ddr_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_bl8;
  logic [1:0]  req_bg;
  logic [1:0]  req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic        cs_n;
  logic        act_n;
  logic        RAS_n_A16;
  logic        CAS_n_A15;
  logic        WE_n_A14;
  logic        A13;
  logic        A12_BC_n;
  logic        A11;
  logic        A10_AP;
  logic [9:0]  A9_A0;
  logic [1:0]  bg_addr;
  logic [1:0]  ba_addr;
  logic        cmd_done;

  modport slave (
    input  req_valid, req_wr, req_bl8, req_bg, req_ba, req_row, req_col,
    output req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    output A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr, cmd_done
  );

  modport master (
    output req_valid, req_wr, req_bl8, req_bg, req_ba, req_row, req_col,
    input  req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    input  A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr, cmd_done
  );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Turns single RD/WR requests into DDR4 PRE/ACT/CAS pin sequences.
// Ports: CK_t, reset (sync, active high), bus (request handshake + command pins).
module ddr_cmd_sequencer #(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_CCD = 4
) (
  input logic CK_t,
  input logic reset,
  ddr_cmd_sequencer_if.slave bus
);
  localparam int MAXW = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam int CCW  = $clog2(T_CCD) + 1;

  localparam logic [4:0] C_NOP = 5'b11111;
  localparam logic [4:0] C_PRE = 5'b01010;

  typedef enum logic [2:0] {
    IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, WAIT_CCD, CAS
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [13:0] adr_q, adr_d;
  logic [1:0]  pbg_q, pbg_d;
  logic [1:0]  pba_q, pba_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CCW-1:0] ccd_q, ccd_d;
  logic [15:0] vld_q, vld_d;
  logic [16:0] row_q [16];
  logic [16:0] row_d [16];
  logic        r_wr_q, r_wr_d;
  logic        r_bl8_q, r_bl8_d;
  logic [1:0]  r_bg_q, r_bg_d;
  logic [1:0]  r_ba_q, r_ba_d;
  logic [16:0] r_row_q, r_row_d;
  logic [9:0]  r_col_q, r_col_d;

  logic [3:0] in_idx;
  logic [3:0] r_idx;
  logic       accept;
  logic       ccd_ok;

  assign in_idx = {bus.req_bg, bus.req_ba};
  assign r_idx  = {r_bg_q, r_ba_q};
  assign accept = bus.req_valid && rdy_q;
  // Decided one edge before the CAS reaches the pins, so look one count ahead.
  assign ccd_ok = (int'(ccd_q) + 1) >= T_CCD;

  always_comb begin
    state_d = state_q;
    cmd_d   = C_NOP;
    adr_d   = '0;
    pbg_d   = '0;
    pba_d   = '0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    ccd_d   = (ccd_q < CCW'(T_CCD)) ? ccd_q + CCW'(1) : ccd_q;
    vld_d   = vld_q;
    row_d   = row_q;
    r_wr_d  = r_wr_q;
    r_bl8_d = r_bl8_q;
    r_bg_d  = r_bg_q;
    r_ba_d  = r_ba_q;
    r_row_d = r_row_q;
    r_col_d = r_col_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          r_wr_d  = bus.req_wr;
          r_bl8_d = bus.req_bl8;
          r_bg_d  = bus.req_bg;
          r_ba_d  = bus.req_ba;
          r_row_d = bus.req_row;
          r_col_d = bus.req_col;
          if (!vld_q[in_idx])
            state_d = ACT;
          else if (row_q[in_idx] != bus.req_row)
            state_d = PRE;
          else
            state_d = ccd_ok ? CAS : WAIT_CCD;
        end
      end
      PRE: begin
        cmd_d = C_PRE;
        pbg_d = r_bg_q;
        pba_d = r_ba_q;
        vld_d[r_idx] = 1'b0;
        if (T_RP == 1) begin
          state_d = ACT;
        end else begin
          state_d = WAIT_RP;
          cnt_d   = CW'(T_RP - 1);
        end
      end
      WAIT_RP: begin
        if (cnt_q == CW'(1)) state_d = ACT;
        else cnt_d = cnt_q - CW'(1);
      end
      ACT: begin
        cmd_d = {2'b00, r_row_q[16:14]};
        adr_d = r_row_q[13:0];
        pbg_d = r_bg_q;
        pba_d = r_ba_q;
        vld_d[r_idx] = 1'b1;
        row_d[r_idx] = r_row_q;
        if (T_RCD == 1) begin
          state_d = ccd_ok ? CAS : WAIT_CCD;
        end else begin
          state_d = WAIT_RCD;
          cnt_d   = CW'(T_RCD - 1);
        end
      end
      WAIT_RCD: begin
        if (cnt_q == CW'(1)) state_d = ccd_ok ? CAS : WAIT_CCD;
        else cnt_d = cnt_q - CW'(1);
      end
      WAIT_CCD: begin
        if (ccd_ok) state_d = CAS;
      end
      CAS: begin
        cmd_d  = {4'b0110, ~r_wr_q};
        adr_d  = {1'b0, r_bl8_q, 2'b00, r_col_q};
        pbg_d  = r_bg_q;
        pba_d  = r_ba_q;
        done_d = 1'b1;
        ccd_d  = CCW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CK_t) begin
    row_q <= row_d;
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= C_NOP;
      adr_q   <= '0;
      pbg_q   <= '0;
      pba_q   <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      ccd_q   <= CCW'(T_CCD);
      vld_q   <= '0;
      r_wr_q  <= 1'b0;
      r_bl8_q <= 1'b0;
      r_bg_q  <= '0;
      r_ba_q  <= '0;
      r_row_q <= '0;
      r_col_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      adr_q   <= adr_d;
      pbg_q   <= pbg_d;
      pba_q   <= pba_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      ccd_q   <= ccd_d;
      vld_q   <= vld_d;
      r_wr_q  <= r_wr_d;
      r_bl8_q <= r_bl8_d;
      r_bg_q  <= r_bg_d;
      r_ba_q  <= r_ba_d;
      r_row_q <= r_row_d;
      r_col_q <= r_col_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign {bus.cs_n, bus.act_n, bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14} = cmd_q;
  assign {bus.A13, bus.A12_BC_n, bus.A11, bus.A10_AP, bus.A9_A0} = adr_q;
  assign bus.bg_addr  = pbg_q;
  assign bus.ba_addr  = pba_q;
  assign bus.cmd_done = done_q;
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer (T_RCD=4, T_RP=3, T_CCD=4).
// Pins are sampled 1ns after each rising edge; inputs change there too.
module tb_ddr_cmd_sequencer;
  logic CK_t;
  logic reset;
  int n_tot;
  int n_pass;

  ddr_cmd_sequencer_if bus();

  ddr_cmd_sequencer #(.T_RCD(4), .T_RP(3), .T_CCD(4)) dut (
    .CK_t(CK_t),
    .reset(reset),
    .bus(bus)
  );

  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  localparam logic [4:0] NOP = 5'b11111;
  localparam logic [4:0] PRE = 5'b01010;
  localparam logic [4:0] RD  = 5'b01101;
  localparam logic [4:0] WR  = 5'b01100;

  function automatic logic [4:0] cmd_pins();
    return {bus.cs_n, bus.act_n, bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14};
  endfunction

  function automatic logic [13:0] adr_pins();
    return {bus.A13, bus.A12_BC_n, bus.A11, bus.A10_AP, bus.A9_A0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CK_t);
    #1;
  endtask

  // Advance one edge and check every pin group plus cmd_done.
  task automatic cyc(input string tag, input logic [4:0] c,
                     input logic [13:0] a, input logic [1:0] bg,
                     input logic [1:0] ba, input logic d);
    step();
    chk({tag, ".cmd"}, 32'(cmd_pins()), 32'(c));
    chk({tag, ".adr"}, 32'(adr_pins()), 32'(a));
    chk({tag, ".bank"}, 32'({bus.bg_addr, bus.ba_addr}), 32'({bg, ba}));
    chk({tag, ".done"}, 32'(bus.cmd_done), 32'(d));
  endtask

  task automatic nop(input string tag);
    cyc(tag, NOP, 14'h0, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic issue(input string tag, input logic wr, input logic bl8,
                       input logic [1:0] bg, input logic [1:0] ba,
                       input logic [16:0] row, input logic [9:0] col);
    bus.req_wr    = wr;
    bus.req_bl8   = bl8;
    bus.req_bg    = bg;
    bus.req_ba    = ba;
    bus.req_row   = row;
    bus.req_col   = col;
    bus.req_valid = 1'b1;
    chk({tag, ".rdy_pre"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk({tag, ".rdy_post"}, 32'(bus.req_ready), 32'd0);
    chk({tag, ".cmd0"}, 32'(cmd_pins()), 32'(NOP));
  endtask

  initial begin
    n_tot  = 0;
    n_pass = 0;
    reset  = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_bl8   = 1'b1;
    bus.req_bg    = 2'd1;
    bus.req_ba    = 2'd2;
    bus.req_row   = 17'h1ABCD;
    bus.req_col   = 10'h155;

    // 1: reset held 3 edges with a request pending
    for (int i = 0; i < 3; i++) begin
      nop("rst");
      chk("rst.rdy", 32'(bus.req_ready), 32'd0);
    end
    reset = 1'b0;
    bus.req_valid = 1'b0;
    nop("rel");
    chk("rel.rdy", 32'(bus.req_ready), 32'd1);

    // 2: closed bank WR
    issue("t2", 1'b1, 1'b1, 2'd1, 2'd2, 17'h1ABCD, 10'h155);
    cyc("t2.act", 5'b00110, 14'h2BCD, 2'd1, 2'd2, 1'b0);
    nop("t2.w1");
    nop("t2.w2");
    nop("t2.w3");
    cyc("t2.wr", WR, 14'h1155, 2'd1, 2'd2, 1'b1);

    // 3: row hit right behind the WR, held off by tCCD
    issue("t3", 1'b0, 1'b1, 2'd1, 2'd2, 17'h1ABCD, 10'h155);
    nop("t3.w1");
    chk("t3.rdy1", 32'(bus.req_ready), 32'd0);
    nop("t3.w2");
    chk("t3.rdy2", 32'(bus.req_ready), 32'd0);
    cyc("t3.rd", RD, 14'h1155, 2'd1, 2'd2, 1'b1);

    // 4: row miss in same bank
    issue("t4", 1'b0, 1'b1, 2'd1, 2'd2, 17'h00010, 10'h155);
    cyc("t4.pre", PRE, 14'h0, 2'd1, 2'd2, 1'b0);
    nop("t4.w1");
    nop("t4.w2");
    cyc("t4.act", 5'b00000, 14'h0010, 2'd1, 2'd2, 1'b0);
    nop("t4.w3");
    nop("t4.w4");
    nop("t4.w5");
    cyc("t4.rd", RD, 14'h1155, 2'd1, 2'd2, 1'b1);

    // 5: other bank, BC4; then a hit back to bank 1/2
    issue("t5", 1'b0, 1'b0, 2'd0, 2'd0, 17'h00123, 10'h0AA);
    cyc("t5.act", 5'b00000, 14'h0123, 2'd0, 2'd0, 1'b0);
    nop("t5.w1");
    nop("t5.w2");
    nop("t5.w3");
    cyc("t5.rd", RD, 14'h00AA, 2'd0, 2'd0, 1'b1);
    nop("t5.i1");
    nop("t5.i2");
    nop("t5.i3");
    issue("t5h", 1'b0, 1'b1, 2'd1, 2'd2, 17'h00010, 10'h3FF);
    cyc("t5h.rd", RD, 14'h13FF, 2'd1, 2'd2, 1'b1);

    // 6: reset in WAIT_RCD drops the request and the open-row table
    issue("t6", 1'b1, 1'b1, 2'd3, 2'd1, 17'h1FFFF, 10'h001);
    cyc("t6.act", 5'b00111, 14'h3FFF, 2'd3, 2'd1, 1'b0);
    nop("t6.w1");
    reset = 1'b1;
    nop("t6.r1");
    nop("t6.r2");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) nop("t6.idle");
    chk("t6.rdy", 32'(bus.req_ready), 32'd1);
    issue("t6b", 1'b1, 1'b1, 2'd3, 2'd1, 17'h1FFFF, 10'h001);
    cyc("t6b.act", 5'b00111, 14'h3FFF, 2'd3, 2'd1, 1'b0);
    nop("t6b.w1");
    nop("t6b.w2");
    nop("t6b.w3");
    cyc("t6b.wr", WR, 14'h1001, 2'd3, 2'd1, 1'b1);

    // bank 1/2 was forgotten by the reset: must re-open with ACT
    issue("t6c", 1'b0, 1'b1, 2'd1, 2'd2, 17'h00010, 10'h155);
    cyc("t6c.act", 5'b00000, 14'h0010, 2'd1, 2'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
